// File: rtl/mannix_layer_sequencer.sv
// Layer descriptor queue and issue sequencer for the mannix accelerator engines.
// Issues one CNN/POOL/FC/SYNC descriptor at a time and waits for the target engine's done.
module mannix_layer_sequencer #(
  parameter int unsigned ADDR_WIDTH = 19,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT_W  = 20
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [ADDR_WIDTH-1:0]         cmd_addr_x,
  input  logic [ADDR_WIDTH-1:0]         cmd_addr_y,
  input  logic [ADDR_WIDTH-1:0]         cmd_addr_b,
  input  logic [ADDR_WIDTH-1:0]         cmd_addr_z,
  input  logic [31:0]                   cmd_dims,
  output logic [ADDR_WIDTH-1:0]         eng_addr_x,
  output logic [ADDR_WIDTH-1:0]         eng_addr_y,
  output logic [ADDR_WIDTH-1:0]         eng_addr_b,
  output logic [ADDR_WIDTH-1:0]         eng_addr_z,
  output logic [31:0]                   eng_dims,
  output logic                          cnn_go,
  output logic                          pool_go,
  output logic                          fc_go,
  input  logic                          cnn_done,
  input  logic                          pool_done,
  input  logic                          fc_done,
  input  logic                          cnn_busy,
  input  logic                          pool_busy,
  input  logic                          fc_busy,
  input  logic [TIMEOUT_W-1:0]          timeout_limit,
  input  logic                          err_clr,
  output logic                          seq_busy,
  output logic                          seq_err,
  output logic [15:0]                   done_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {OpCnn = 2'd0, OpPool = 2'd1, OpFc = 2'd2, OpSync = 2'd3} op_e;
  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  typedef struct packed {
    op_e                   op;
    logic [ADDR_WIDTH-1:0] addr_x;
    logic [ADDR_WIDTH-1:0] addr_y;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [ADDR_WIDTH-1:0] addr_z;
    logic [31:0]           dims;
  } desc_t;

  desc_t               mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]       count_q;
  logic                full, empty, push, pop;
  desc_t               desc_in, head;

  state_e              state_q;
  op_e                 op_q;
  logic [TIMEOUT_W-1:0] timer_q;
  logic [TIMEOUT_W:0]  timer_inc;
  logic                timeout_hit;
  logic                target_busy, target_done;
  logic                cnn_go_q, pool_go_q, fc_go_q;

  assign full    = (count_q == (PtrW+1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign push    = cmd_valid && !full;
  assign desc_in = '{op: op_e'(cmd_op), addr_x: cmd_addr_x, addr_y: cmd_addr_y,
                     addr_b: cmd_addr_b, addr_z: cmd_addr_z, dims: cmd_dims};
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    target_busy = 1'b0;
    target_done = 1'b0;
    unique case (op_q)
      OpCnn:   begin target_busy = cnn_busy;  target_done = cnn_done;  end
      OpPool:  begin target_busy = pool_busy; target_done = pool_done; end
      OpFc:    begin target_busy = fc_busy;   target_done = fc_done;   end
      default: ;
    endcase
  end

  // The entry leaves the FIFO on the edge the FSM leaves ISSUE.
  assign pop = (state_q == StIssue) && ((op_q == OpSync) || !target_busy);

  assign timer_inc   = {1'b0, timer_q} + 1'b1;
  assign timeout_hit = (timeout_limit != '0) && (timer_inc >= {1'b0, timeout_limit});

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= desc_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_q       <= OpCnn;
      eng_addr_x <= '0;
      eng_addr_y <= '0;
      eng_addr_b <= '0;
      eng_addr_z <= '0;
      eng_dims   <= '0;
      cnn_go_q   <= 1'b0;
      pool_go_q  <= 1'b0;
      fc_go_q    <= 1'b0;
      timer_q    <= '0;
      done_cnt   <= '0;
      seq_err    <= 1'b0;
    end else begin
      cnn_go_q  <= 1'b0;
      pool_go_q <= 1'b0;
      fc_go_q   <= 1'b0;
      if (err_clr) seq_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            op_q       <= head.op;
            eng_addr_x <= head.addr_x;
            eng_addr_y <= head.addr_y;
            eng_addr_b <= head.addr_b;
            eng_addr_z <= head.addr_z;
            eng_dims   <= head.dims;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          if (op_q == OpSync) begin
            done_cnt <= done_cnt + 16'd1;
            state_q  <= StIdle;
          end else if (!target_busy) begin
            cnn_go_q  <= (op_q == OpCnn);
            pool_go_q <= (op_q == OpPool);
            fc_go_q   <= (op_q == OpFc);
            timer_q   <= '0;
            state_q   <= StWait;
          end
        end
        StWait: begin
          if (target_done) begin
            done_cnt <= done_cnt + 16'd1;
            state_q  <= StIdle;
          end else if (timeout_hit) begin
            seq_err <= 1'b1;  // overrides a coincident err_clr
            state_q <= StIdle;
          end else if (timer_q != '1) begin
            timer_q <= timer_inc[TIMEOUT_W-1:0];
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cnn_go     = cnn_go_q;
  assign pool_go    = pool_go_q;
  assign fc_go      = fc_go_q;
  assign cmd_ready  = !full;
  assign seq_busy   = !empty || (state_q != StIdle);
  assign fifo_level = count_q;

endmodule

// File: tb/tb_mannix_layer_sequencer.sv
// Directed bench for mannix_layer_sequencer: issue timing, FIFO backpressure, busy hold,
// timeout, foreign done pulses, SYNC descriptors and mid-layer reset.
module tb_mannix_layer_sequencer;

  localparam int unsigned AW = 19;
  localparam int unsigned TW = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr_x, cmd_addr_y, cmd_addr_b, cmd_addr_z;
  logic [31:0]   cmd_dims;
  logic [AW-1:0] eng_addr_x, eng_addr_y, eng_addr_b, eng_addr_z;
  logic [31:0]   eng_dims;
  logic          cnn_go, pool_go, fc_go;
  logic          cnn_done, pool_done, fc_done;
  logic          cnn_busy, pool_busy, fc_busy;
  logic [TW-1:0] timeout_limit;
  logic          err_clr, seq_busy, seq_err;
  logic [15:0]   done_cnt;
  logic [2:0]    fifo_level;

  int n_chk  = 0;
  int n_fail = 0;

  mannix_layer_sequencer #(.ADDR_WIDTH(AW), .FIFO_DEPTH(4), .TIMEOUT_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr_x(cmd_addr_x), .cmd_addr_y(cmd_addr_y), .cmd_addr_b(cmd_addr_b),
    .cmd_addr_z(cmd_addr_z), .cmd_dims(cmd_dims),
    .eng_addr_x(eng_addr_x), .eng_addr_y(eng_addr_y), .eng_addr_b(eng_addr_b),
    .eng_addr_z(eng_addr_z), .eng_dims(eng_dims),
    .cnn_go(cnn_go), .pool_go(pool_go), .fc_go(fc_go),
    .cnn_done(cnn_done), .pool_done(pool_done), .fc_done(fc_done),
    .cnn_busy(cnn_busy), .pool_busy(pool_busy), .fc_busy(fc_busy),
    .timeout_limit(timeout_limit), .err_clr(err_clr),
    .seq_busy(seq_busy), .seq_err(seq_err), .done_cnt(done_cnt), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [AW-1:0] x, input logic [AW-1:0] y,
                       input logic [AW-1:0] b, input logic [AW-1:0] z, input logic [31:0] d);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_addr_x = x;
    cmd_addr_y = y;
    cmd_addr_b = b;
    cmd_addr_z = z;
    cmd_dims   = d;
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'd0;
    cmd_addr_x = '0; cmd_addr_y = '0; cmd_addr_b = '0; cmd_addr_z = '0; cmd_dims = '0;
    cnn_done = 1'b0; pool_done = 1'b0; fc_done = 1'b0;
    cnn_busy = 1'b0; pool_busy = 1'b0; fc_busy = 1'b0;
    timeout_limit = '0; err_clr = 1'b0;
    tick(2);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", seq_busy, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_done_cnt", done_cnt, 0);
    chk("rst_err", seq_err, 0);
    chk("rst_go", {cnn_go, pool_go, fc_go}, 0);
    chk("rst_eng_x", eng_addr_x, 0);
    rst_n = 1'b1;
    tick(1);

    // 1: single CNN layer
    drive(2'd0, 19'h100, 19'h200, 19'h300, 19'h400, 32'h0808_0303);
    tick(1);
    cmd_valid = 1'b0;
    chk("t1_level_push", fifo_level, 1);
    chk("t1_busy", seq_busy, 1);
    chk("t1_go_early", cnn_go, 0);
    tick(1);
    chk("t1_go_issue", cnn_go, 0);
    chk("t1_eng_x", eng_addr_x, 19'h100);
    chk("t1_eng_y", eng_addr_y, 19'h200);
    chk("t1_eng_b", eng_addr_b, 19'h300);
    chk("t1_eng_z", eng_addr_z, 19'h400);
    chk("t1_eng_dims", eng_dims, 32'h0808_0303);
    tick(1);
    chk("t1_go", {cnn_go, pool_go, fc_go}, 3'b100);
    chk("t1_level_pop", fifo_level, 0);
    tick(1);
    chk("t1_go_drop", cnn_go, 0);
    tick(7);
    chk("t1_wait_cnt", done_cnt, 0);
    cnn_done = 1'b1;
    tick(1);
    cnn_done = 1'b0;
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_busy_fall", seq_busy, 0);
    chk("t1_eng_hold", eng_addr_x, 19'h100);

    // 2: fill FIFO behind a busy CNN engine
    cnn_busy = 1'b1;
    drive(2'd0, 19'h11, 19'h1, 19'h2, 19'h3, 32'h1);
    tick(1);
    drive(2'd1, 19'h22, 19'h1, 19'h2, 19'h3, 32'h2);
    tick(1);
    drive(2'd2, 19'h33, 19'h1, 19'h2, 19'h3, 32'h3);
    tick(1);
    drive(2'd0, 19'h44, 19'h1, 19'h2, 19'h3, 32'h4);
    tick(1);
    chk("t2_full_ready", cmd_ready, 0);
    chk("t2_full_level", fifo_level, 4);
    drive(2'd3, 19'h55, 19'h1, 19'h2, 19'h3, 32'h5);
    tick(2);
    chk("t2_held_level", fifo_level, 4);
    chk("t2_held_go", cnn_go, 0);
    cnn_busy = 1'b0;
    tick(1);
    cmd_valid = 1'b0;
    chk("t2_cnn_go", cnn_go, 1);
    chk("t2_ready_rise", cmd_ready, 1);
    chk("t2_level_pop", fifo_level, 3);
    chk("t2_order0", eng_addr_x, 19'h11);

    // 3: POOL held by pool_busy
    pool_busy = 1'b1;
    tick(1);
    cnn_done = 1'b1;
    tick(1);
    cnn_done = 1'b0;
    chk("t2_done_cnt", done_cnt, 2);
    tick(1);
    chk("t3_order1", eng_addr_x, 19'h22);
    tick(3);
    chk("t3_no_go", pool_go, 0);
    chk("t3_level_hold", fifo_level, 3);
    pool_busy = 1'b0;
    tick(1);
    chk("t3_pool_go", {cnn_go, pool_go, fc_go}, 3'b010);
    tick(1);
    chk("t3_go_drop", pool_go, 0);
    pool_done = 1'b1;
    tick(1);
    pool_done = 1'b0;
    chk("t3_done_cnt", done_cnt, 3);

    // 4: FC timeout
    timeout_limit = 20'd5;
    tick(1);
    chk("t4_order2", eng_addr_x, 19'h33);
    tick(1);
    chk("t4_fc_go", {cnn_go, pool_go, fc_go}, 3'b001);
    tick(4);
    chk("t4_err_early", seq_err, 0);
    tick(1);
    chk("t4_err_set", seq_err, 1);
    chk("t4_cnt_same", done_cnt, 3);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("t4_err_clr", seq_err, 0);
    chk("t4_next_issue", eng_addr_x, 19'h44);

    // 5: foreign done pulses during a CNN wait
    tick(1);
    chk("t5_cnn_go", cnn_go, 1);
    tick(1);
    pool_done = 1'b1;
    fc_done = 1'b1;
    tick(1);
    pool_done = 1'b0;
    fc_done = 1'b0;
    chk("t5_ignored_cnt", done_cnt, 3);
    chk("t5_ignored_busy", seq_busy, 1);
    cnn_done = 1'b1;
    tick(1);
    cnn_done = 1'b0;
    chk("t5_done_cnt", done_cnt, 4);
    chk("t5_idle", seq_busy, 0);
    chk("t5_no_err", seq_err, 0);
    timeout_limit = '0;

    // 6: SYNC descriptor, then reset mid-layer
    drive(2'd3, 19'h5, 19'h6, 19'h7, 19'h8, 32'h9);
    tick(1);
    cmd_valid = 1'b0;
    tick(1);
    chk("t6_sync_go1", {cnn_go, pool_go, fc_go}, 0);
    tick(1);
    chk("t6_sync_go2", {cnn_go, pool_go, fc_go}, 0);
    chk("t6_sync_cnt", done_cnt, 5);
    chk("t6_sync_level", fifo_level, 0);

    drive(2'd0, 19'h66, 19'h1, 19'h2, 19'h3, 32'h6);
    tick(1);
    drive(2'd0, 19'h77, 19'h1, 19'h2, 19'h3, 32'h7);
    tick(1);
    cmd_valid = 1'b0;
    tick(1);
    chk("t6_pre_rst_go", cnn_go, 1);
    chk("t6_pre_rst_level", fifo_level, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_go", cnn_go, 0);
    chk("t6_rst_level", fifo_level, 0);
    chk("t6_rst_cnt", done_cnt, 0);
    chk("t6_rst_busy", seq_busy, 0);
    chk("t6_rst_ready", cmd_ready, 1);
    chk("t6_rst_eng", eng_addr_x, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("t6_post_rst_busy", seq_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
